// File: rtl/ycr_div_arb.sv
// Two-port front end for a shared ycr_pipe_div: arbitrates, builds sign-tagged
// operands, sequences the divider handshake and reuses the last divide result.
module ycr_div_arb #(
  parameter bit CACHE_EN = 1'b1,
  parameter bit RR_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_vld_i,
  input  logic [1:0]  req_op0_i,
  input  logic [1:0]  req_op1_i,
  input  logic [31:0] req_src1_0_i,
  input  logic [31:0] req_src1_1_i,
  input  logic [31:0] req_src2_0_i,
  input  logic [31:0] req_src2_1_i,
  input  logic [1:0]  req_kill_i,
  output logic [1:0]  rsp_vld_o,
  output logic [31:0] rsp_data_o,
  output logic        busy_o,
  output logic        div_data_valid_o,
  output logic [32:0] div_din1_o,
  output logic [32:0] div_din2_o,
  input  logic [31:0] div_quotient_i,
  input  logic [31:0] div_remainder_i,
  input  logic        div_rdy_i,
  output logic        div_data_done_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HIT   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        port_q, port_d;
  logic [1:0]  op_q, op_d;
  logic [32:0] din1_q, din1_d;
  logic [32:0] din2_q, din2_d;
  logic        prio_q, prio_d;
  logic        killed_q, killed_d;

  logic        c_vld_q, c_vld_d;
  logic        c_sgn_q, c_sgn_d;
  logic [31:0] c_src1_q, c_src1_d;
  logic [31:0] c_src2_q, c_src2_d;
  logic [31:0] c_quo_q, c_quo_d;
  logic [31:0] c_rem_q, c_rem_d;

  logic [1:0]  req_eff;
  logic        any_req;
  logic        sel;
  logic [1:0]  sel_op;
  logic [31:0] sel_src1;
  logic [31:0] sel_src2;
  logic        sel_sgn;
  logic        hit;
  logic        resp_fire;

  // Request qualification, grant choice and cache lookup for the IDLE decision
  always_comb begin
    req_eff  = req_vld_i & ~req_kill_i;
    any_req  = |req_eff;
    sel      = 1'b0;
    if (req_eff == 2'b11) begin
      sel = RR_EN ? prio_q : 1'b0;
    end else if (req_eff == 2'b10) begin
      sel = 1'b1;
    end
    sel_op   = sel ? req_op1_i    : req_op0_i;
    sel_src1 = sel ? req_src1_1_i : req_src1_0_i;
    sel_src2 = sel ? req_src2_1_i : req_src2_0_i;
    sel_sgn  = ~sel_op[0];
    hit      = CACHE_EN && c_vld_q && (c_src1_q == sel_src1) &&
               (c_src2_q == sel_src2) && (c_sgn_q == sel_sgn);
  end

  always_comb begin
    state_d          = state_q;
    port_d           = port_q;
    op_d             = op_q;
    din1_d           = din1_q;
    din2_d           = din2_q;
    prio_d           = prio_q;
    killed_d         = killed_q;
    c_vld_d          = c_vld_q;
    c_sgn_d          = c_sgn_q;
    c_src1_d         = c_src1_q;
    c_src2_d         = c_src2_q;
    c_quo_d          = c_quo_q;
    c_rem_d          = c_rem_q;
    div_data_valid_o = 1'b0;
    div_data_done_o  = 1'b0;
    rsp_vld_o        = 2'b00;
    rsp_data_o       = 32'd0;
    resp_fire        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          port_d   = sel;
          op_d     = sel_op;
          prio_d   = ~sel;
          killed_d = 1'b0;
          if (hit) begin
            state_d = S_HIT;
          end else begin
            din1_d  = {sel_sgn & sel_src1[31], sel_src1};
            din2_d  = {sel_sgn & sel_src2[31], sel_src2};
            state_d = S_ISSUE;
          end
        end
      end
      S_HIT: begin
        resp_fire = 1'b1;
        state_d   = S_IDLE;
      end
      S_ISSUE: begin
        div_data_valid_o = 1'b1;
        state_d          = S_WAIT;
      end
      S_WAIT: begin
        // Cache is refreshed even for a killed request; the divide did run
        if (div_rdy_i) begin
          c_vld_d  = 1'b1;
          c_sgn_d  = ~op_q[0];
          c_src1_d = din1_q[31:0];
          c_src2_d = din2_q[31:0];
          c_quo_d  = div_quotient_i;
          c_rem_d  = div_remainder_i;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        div_data_done_o = 1'b1;
        resp_fire       = 1'b1;
        state_d         = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (((state_q == S_ISSUE) || (state_q == S_WAIT)) && req_kill_i[port_q]) begin
      killed_d = 1'b1;
    end

    if (resp_fire && !killed_q && !req_kill_i[port_q]) begin
      rsp_vld_o[port_q] = 1'b1;
      rsp_data_o        = op_q[1] ? c_rem_q : c_quo_q;
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign div_din1_o = din1_q;
  assign div_din2_o = din2_q;

  // Control state and divider-facing operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      port_q   <= 1'b0;
      op_q     <= 2'b00;
      din1_q   <= 33'd0;
      din2_q   <= 33'd0;
      prio_q   <= 1'b0;
      killed_q <= 1'b0;
      c_vld_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      op_q     <= op_d;
      din1_q   <= din1_d;
      din2_q   <= din2_d;
      prio_q   <= prio_d;
      killed_q <= killed_d;
      c_vld_q  <= c_vld_d;
    end
  end

  // Cache payload is qualified by c_vld_q, so it needs no reset
  always_ff @(posedge clk) begin
    c_sgn_q  <= c_sgn_d;
    c_src1_q <= c_src1_d;
    c_src2_q <= c_src2_d;
    c_quo_q  <= c_quo_d;
    c_rem_q  <= c_rem_d;
  end

endmodule

// File: tb/tb_ycr_div_arb.sv
// Directed bench for ycr_div_arb: a behavioural divider stands in for ycr_pipe_div;
// instance 0 has the result cache enabled, instance 1 has it disabled.
module tb_ycr_div_arb;

  logic        clk;
  logic        rst;
  logic [1:0]  req_vld  [2];
  logic [1:0]  req_kill [2];
  logic [1:0]  op_r     [2][2];
  logic [31:0] src1     [2][2];
  logic [31:0] src2     [2][2];
  logic [1:0]  rsp_vld  [2];
  logic [31:0] rsp_data [2];
  logic        busy     [2];
  logic        dvalid   [2];
  logic        ddone    [2];
  logic [32:0] din1     [2];
  logic [32:0] din2     [2];

  int n_vec;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [4:0]         cnt;
    logic [31:0]        q_r;
    logic [31:0]        r_r;
    logic               rdy;
    logic signed [32:0] sa;
    logic signed [32:0] sb;
    logic signed [32:0] qf;
    logic signed [32:0] rf;
    logic [32:0]        h1;
    logic [32:0]        h2;
    logic               trk;
    int                 stab_err = 0;

    ycr_div_arb #(.CACHE_EN(g == 0), .RR_EN(1'b1)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .req_vld_i       (req_vld[g]),
      .req_op0_i       (op_r[g][0]),
      .req_op1_i       (op_r[g][1]),
      .req_src1_0_i    (src1[g][0]),
      .req_src1_1_i    (src1[g][1]),
      .req_src2_0_i    (src2[g][0]),
      .req_src2_1_i    (src2[g][1]),
      .req_kill_i      (req_kill[g]),
      .rsp_vld_o       (rsp_vld[g]),
      .rsp_data_o      (rsp_data[g]),
      .busy_o          (busy[g]),
      .div_data_valid_o(dvalid[g]),
      .div_din1_o      (din1[g]),
      .div_din2_o      (din2[g]),
      .div_quotient_i  (q_r),
      .div_remainder_i (r_r),
      .div_rdy_i       (rdy),
      .div_data_done_o (ddone[g])
    );

    // Divider stand-in: rdy 18 cycles after data_valid, 2 cycles for a zero divisor
    assign sa  = din1[g];
    assign sb  = din2[g];
    assign qf  = (sb == 0) ? 33'sd0 : sa / sb;
    assign rf  = (sb == 0) ? 33'sd0 : sa % sb;
    assign rdy = (cnt == 5'd1);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= 5'd0;
        q_r <= 32'd0;
        r_r <= 32'd0;
      end else if (dvalid[g]) begin
        cnt <= (din2[g][31:0] == 32'd0) ? 5'd2 : 5'd18;
        q_r <= (sb == 0) ? 32'hFFFF_FFFF : qf[31:0];
        r_r <= (sb == 0) ? sa[31:0] : rf[31:0];
      end else if (cnt != 5'd0) begin
        cnt <= cnt - 5'd1;
      end
    end

    // Operands must hold from the data_valid cycle through data_done
    always @(negedge clk) begin
      if (rst) begin
        trk <= 1'b0;
      end else if (dvalid[g]) begin
        trk <= 1'b1;
        h1  <= din1[g];
        h2  <= din2[g];
      end else if (trk) begin
        if (din1[g] !== h1 || din2[g] !== h2) stab_err <= stab_err + 1;
        if (ddone[g]) trk <= 1'b0;
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_zero(input int inst, input string nm);
    check({nm, " ctrl"}, {rsp_vld[inst], busy[inst], dvalid[inst], ddone[inst]}, 0);
    check({nm, " data"}, rsp_data[inst], 0);
    check({nm, " din1"}, din1[inst], 0);
    check({nm, " din2"}, din2[inst], 0);
  endtask

  task automatic wait_idle(input int inst);
    int k;
    k = 0;
    while ((busy[inst] || rsp_vld[inst] != 2'b00) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("idle timeout", 1, 0);
  endtask

  task automatic run_req(input int inst, input int port, input logic [1:0] op,
                         input logic [31:0] s1, input logic [31:0] s2,
                         input logic [31:0] exp_d, input int exp_lat, input int exp_vc,
                         input string nm);
    int c, vc, done_c, din_bad, quiet_bad;
    bit seen;
    logic [32:0] e1, e2;
    wait_idle(inst);
    e1 = {~op[0] & s1[31], s1};
    e2 = {~op[0] & s2[31], s2};
    op_r[inst][port] = op;
    src1[inst][port] = s1;
    src2[inst][port] = s2;
    req_vld[inst][port] = 1'b1;
    seen = 0; c = 0; vc = 0; done_c = -1; din_bad = 0; quiet_bad = 0;
    while (!seen && c < 60) begin
      @(posedge clk);
      @(negedge clk);
      c++;
      if (dvalid[inst]) begin
        vc++;
        if (din1[inst] !== e1 || din2[inst] !== e2) din_bad++;
      end
      if (ddone[inst] && done_c < 0) done_c = c;
      if (rsp_vld[inst] != 2'b00) seen = 1;
      else if (rsp_data[inst] != 32'd0) quiet_bad++;
    end
    check({nm, " latency"}, seen ? c : -1, exp_lat);
    if (seen) begin
      check({nm, " port"}, rsp_vld[inst], 2'b01 << port);
      check({nm, " data"}, rsp_data[inst], exp_d);
    end
    check({nm, " valid pulses"}, vc, exp_vc);
    check({nm, " quiet data"}, quiet_bad, 0);
    if (exp_vc > 0) begin
      check({nm, " operands"}, din_bad, 0);
      check({nm, " done cycle"}, done_c, exp_lat);
    end
    req_vld[inst][port] = 1'b0;
  endtask

  typedef struct {
    int          inst;
    int          port;
    logic [1:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] exp_d;
    int          lat;
    int          vc;
  } vec_t;

  vec_t        tbl [14];
  logic [1:0]  rr_vld_exp  [3];
  logic [31:0] rr_data_exp [3];
  int          nresp, done_c, rsp0, issue1, rsp1c, bsy;
  logic [31:0] d1;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 2; i++) begin
      req_vld[i]  = 2'b00;
      req_kill[i] = 2'b00;
      for (int p = 0; p < 2; p++) begin
        op_r[i][p] = 2'b00;
        src1[i][p] = 32'd0;
        src2[i][p] = 32'd0;
      end
    end

    //            inst port op     src1           src2           expected     lat vc
    tbl[0]  = '{0, 0, 2'b01, 32'd100,       32'd7,         32'd14,        20, 1};
    tbl[1]  = '{0, 0, 2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 20, 1};
    tbl[2]  = '{0, 0, 2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF,  1, 0};
    tbl[3]  = '{0, 1, 2'b11, 32'd55,        32'd0,         32'd55,         4, 1};
    tbl[4]  = '{0, 1, 2'b01, 32'd55,        32'd0,         32'hFFFF_FFFF,  1, 0};
    tbl[5]  = '{0, 0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 20, 1};
    tbl[6]  = '{0, 0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          1, 0};
    tbl[7]  = '{0, 1, 2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 20, 1};
    tbl[8]  = '{0, 1, 2'b00, 32'd0,         32'd0,         32'hFFFF_FFFF,  4, 1};
    tbl[9]  = '{0, 0, 2'b11, 32'hFFFF_FFFF, 32'd16,        32'd15,        20, 1};
    tbl[10] = '{0, 0, 2'b01, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF,  1, 0};
    tbl[11] = '{0, 0, 2'b00, 32'hFFFF_FFFF, 32'd16,        32'd0,         20, 1};
    tbl[12] = '{1, 0, 2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 20, 1};
    tbl[13] = '{1, 0, 2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 20, 1};

    rr_vld_exp[0]  = 2'b01; rr_data_exp[0] = 32'd100;
    rr_vld_exp[1]  = 2'b10; rr_data_exp[1] = 32'd6;
    rr_vld_exp[2]  = 2'b01; rr_data_exp[2] = 32'd666;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero(0, "reset");
    check_zero(1, "reset nc");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      run_req(tbl[i].inst, tbl[i].port, tbl[i].op, tbl[i].s1, tbl[i].s2,
              tbl[i].exp_d, tbl[i].lat, tbl[i].vc, $sformatf("vec%0d", i));
    end

    // Round robin: both ports keep requesting; reset first so port 0 has priority
    wait_idle(0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    op_r[0][0] = 2'b01; src1[0][0] = 32'd1000; src2[0][0] = 32'd10;
    op_r[0][1] = 2'b11; src1[0][1] = 32'd1000; src2[0][1] = 32'd7;
    req_vld[0] = 2'b11;
    nresp = 0;
    for (int c = 1; c <= 100 && nresp < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_vld[0] != 2'b00) begin
        check($sformatf("rr grant %0d", nresp), rsp_vld[0], rr_vld_exp[nresp]);
        check($sformatf("rr data %0d", nresp), rsp_data[0], rr_data_exp[nresp]);
        if (nresp == 0) begin src1[0][0] = 32'd2000; src2[0][0] = 32'd3; end
        if (nresp == 1) begin src1[0][1] = 32'd50;   src2[0][1] = 32'd8; end
        nresp++;
      end
    end
    req_vld[0] = 2'b00;
    check("rr responses", nresp, 3);

    // Kill port 0 mid-divide while port 1 waits
    wait_idle(0);
    op_r[0][0] = 2'b01; src1[0][0] = 32'd100; src2[0][0] = 32'd7;
    req_vld[0][0] = 1'b1;
    done_c = -1; rsp0 = 0; issue1 = -1; rsp1c = -1; d1 = 32'd0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_vld[0][0]) rsp0++;
      if (ddone[0] && done_c < 0) done_c = c;
      if (dvalid[0] && c > 1 && issue1 < 0) issue1 = c;
      if (rsp_vld[0][1] && rsp1c < 0) begin
        rsp1c = c;
        d1 = rsp_data[0];
        req_vld[0][1] = 1'b0;
      end
      req_kill[0] = 2'b00;
      if (c == 2) begin
        op_r[0][1] = 2'b01; src1[0][1] = 32'd90; src2[0][1] = 32'd9;
        req_vld[0][1] = 1'b1;
      end
      if (c == 9) begin
        req_kill[0][0] = 1'b1;
        req_vld[0][0]  = 1'b0;
      end
    end
    check("kill done cycle", done_c, 20);
    check("kill rsp0 count", rsp0, 0);
    check("kill p1 issue", issue1, 22);
    check("kill p1 rsp cycle", rsp1c, 41);
    check("kill p1 data", d1, 32'd10);

    // Killed divide still fills the cache
    wait_idle(0);
    op_r[0][0] = 2'b01; src1[0][0] = 32'd300; src2[0][0] = 32'd7;
    req_vld[0][0] = 1'b1;
    done_c = 0; rsp0 = 0;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_vld[0] != 2'b00) rsp0++;
      if (ddone[0]) done_c++;
      req_kill[0] = 2'b00;
      if (c == 4) begin
        req_kill[0][0] = 1'b1;
        req_vld[0][0]  = 1'b0;
      end
    end
    check("kill2 done pulses", done_c, 1);
    check("kill2 rsp count", rsp0, 0);
    run_req(0, 0, 2'b11, 32'd300, 32'd7, 32'd6, 1, 0, "killed cache hit");

    // Request killed while still pending in IDLE is ignored
    wait_idle(0);
    req_vld[0][1]  = 1'b1;
    req_kill[0][1] = 1'b1;
    bsy = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy[0] || dvalid[0]) bsy++;
    end
    req_vld[0]  = 2'b00;
    req_kill[0] = 2'b00;
    check("idle kill ignored", bsy, 0);

    // Reset in the middle of WAIT
    wait_idle(0);
    op_r[0][0] = 2'b01; src1[0][0] = 32'd1234; src2[0][0] = 32'd5;
    req_vld[0][0] = 1'b1;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check_zero(0, "mid reset");
    req_vld[0] = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_req(0, 0, 2'b11, 32'd300, 32'd7, 32'd6, 20, 1, "after reset");

    wait_idle(0);
    check("operand stability", g_inst[0].stab_err + g_inst[1].stab_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
